// File: rtl/contador_pkg.sv
// Shared constants for the contador counter family: mode codes, lower-stage width
// and snapshot FSM state encoding.
package contador_pkg;

    localparam int LOW_W = 4;

    localparam logic [1:0] MODE_UP3  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP1  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } snap_state_e;

    // Wrap/limit point of the upper count: zero when counting down, all-ones otherwise.
    function automatic logic upper_at_limit(input logic [1:0] mode,
                                            input logic       at_zero,
                                            input logic       at_ones);
        logic lim;
        if (mode == MODE_DN1) begin
            lim = at_zero;
        end else begin
            lim = at_ones;
        end
        return lim;
    endfunction

endpackage

// File: rtl/contador_snap_hs.sv
// Snapshot capture with valid/ready handshake; counting upstream never waits on it.
module contador_snap_hs
    import contador_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         snap_req,
    input  logic         snap_ready,
    input  logic [W-1:0] cap_data,
    output logic         snap_valid,
    output logic [W-1:0] snap_data,
    output logic         snap_ovr
);

    snap_state_e  state_q, state_d;
    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         ovr_q,   ovr_d;

    // Next-state and capture logic; a request seen while holding marks an overrun.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    data_d  = cap_data;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (snap_req) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (snap_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and snapshot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign snap_valid = valid_q;
    assign snap_data  = data_q;
    assign snap_ovr   = ovr_q;

endmodule

// File: rtl/contador_cascade_hi.sv
// Upper cascade stage for the 4-bit contadorA counter, extending it to HI_W+4 bits.
// Optional build macro CASCADE_SATURATE_EN: upper count holds at its limit instead of wrapping.
module contador_cascade_hi
    import contador_pkg::*;
#(
    parameter int HI_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [HI_W-1:0]       D_hi,
    input  logic [LOW_W-1:0]      low_Q,
    input  logic                  low_rco,
    input  logic                  low_load,
    output logic [HI_W+LOW_W-1:0] Q_full,
    output logic                  rco,
    output logic                  load,
    input  logic                  snap_req,
    output logic                  snap_valid,
    output logic [HI_W+LOW_W-1:0] snap_data,
    input  logic                  snap_ready,
    output logic                  snap_ovr
);

    localparam int            FULL_W = HI_W + LOW_W;
    localparam logic [HI_W-1:0] ONE_HI = {{(HI_W-1){1'b0}}, 1'b1};

    logic [HI_W-1:0]   upper_q, upper_d;
    logic [FULL_W-1:0] q_full_q, q_full_d;
    logic              rco_q, rco_d;
    logic              load_q, load_d;
    logic              limit_s;

    // Upper-count next state; it only steps when the lower stage reports a wrap.
    always_comb begin
        limit_s = upper_at_limit(mode, ~|upper_q, &upper_q);
        upper_d = upper_q;
        if (!enable) begin
            upper_d = upper_q;
        end else if (mode == MODE_LOAD) begin
            upper_d = D_hi;
        end else if (low_rco) begin
`ifdef CASCADE_SATURATE_EN
            if (limit_s) begin
                upper_d = upper_q;
            end else if (mode == MODE_DN1) begin
                upper_d = upper_q - ONE_HI;
            end else begin
                upper_d = upper_q + ONE_HI;
            end
`else
            if (mode == MODE_DN1) begin
                upper_d = upper_q - ONE_HI;
            end else begin
                upper_d = upper_q + ONE_HI;
            end
`endif
        end else begin
            upper_d = upper_q;
        end
        rco_d    = enable & low_rco & (mode != MODE_LOAD) & limit_s;
        load_d   = enable & (mode == MODE_LOAD) & low_load;
        q_full_d = {upper_d, low_Q};
    end

    // Counter and output registers; Q_full re-registers low_Q so both halves align.
    always_ff @(posedge clk) begin
        if (reset) begin
            upper_q  <= {HI_W{1'b0}};
            q_full_q <= {FULL_W{1'b0}};
            rco_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            upper_q  <= upper_d;
            q_full_q <= q_full_d;
            rco_q    <= rco_d;
            load_q   <= load_d;
        end
    end

    assign Q_full = q_full_q;
    assign rco    = rco_q;
    assign load   = load_q;

    contador_snap_hs #(
        .W (FULL_W)
    ) u_snap (
        .clk        (clk),
        .reset      (reset),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .cap_data   (q_full_d),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .snap_ovr   (snap_ovr)
    );

endmodule
